// File: rtl/eq_gain_ramp_scheduler.sv
// Gain ramp scheduler for the 3-band EQ: walks each band's applied gain toward its clamped target one code per update.
// Latency: request rises on the first sample strobe that sees a pending band; the accepted code lands on gain_o at the handshake edge.
// Backpressure: request, band and gain are held while upd_ready_i is low; strobes during a request are ignored and not counted.
module eq_gain_ramp_scheduler #(
  parameter int GAIN_WD      = 3,
  parameter int GAIN_MAX     = 5,
  parameter int HOLD_SAMPLES = 4,
  parameter int HOLD_WD      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_en_i,
  input  logic [2:0][GAIN_WD-1:0]  target_gain_i,
  input  logic                     upd_ready_i,
  output logic                     upd_valid_o,
  output logic [1:0]               upd_band_o,
  output logic [GAIN_WD-1:0]       upd_gain_o,
  output logic [2:0][GAIN_WD-1:0]  gain_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [GAIN_WD-1:0] GAIN_MAX_C = GAIN_WD'(GAIN_MAX);
  localparam logic [HOLD_WD-1:0] HOLD_LOAD  = HOLD_WD'(HOLD_SAMPLES);
  localparam logic [HOLD_WD-1:0] HOLD_ONE   = HOLD_WD'(1);

  state_t                    state_q, state_d;
  logic [2:0][GAIN_WD-1:0]   gain_q, gain_d;
  logic [2:0][GAIN_WD-1:0]   tgt;
  logic [2:0]                pending;
  logic [1:0]                band_q, band_d;
  logic [1:0]                rr_q, rr_d;
  logic [GAIN_WD-1:0]        ugain_q, ugain_d;
  logic [HOLD_WD-1:0]        hold_q, hold_d;
  logic [1:0]                cand0, cand1, cand2;
  logic [1:0]                win_band;
  logic                      win_found;
  logic [GAIN_WD-1:0]        win_step;
  logic                      handshake;

  // Band index successor over the three bands (2 wraps to 0).
  function automatic logic [1:0] next_band(input logic [1:0] b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

  // Clamp each requested gain and flag bands whose applied gain differs from it.
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      tgt[b]     = (target_gain_i[b] > GAIN_MAX_C) ? GAIN_MAX_C : target_gain_i[b];
      pending[b] = (gain_q[b] != tgt[b]);
    end
  end

  // Search order for the round-robin pick, starting at the pointer.
  assign cand0 = rr_q;
  assign cand1 = next_band(rr_q);
  assign cand2 = next_band(next_band(rr_q));

  // First pending band in search order, and the one-code step toward its target.
  always_comb begin
    win_found = 1'b0;
    win_band  = 2'd0;
    if (pending[cand2]) begin
      win_found = 1'b1;
      win_band  = cand2;
    end
    if (pending[cand1]) begin
      win_found = 1'b1;
      win_band  = cand1;
    end
    if (pending[cand0]) begin
      win_found = 1'b1;
      win_band  = cand0;
    end
    win_step = (tgt[win_band] > gain_q[win_band]) ? gain_q[win_band] + GAIN_WD'(1)
                                                  : gain_q[win_band] - GAIN_WD'(1);
  end

  assign handshake = (state_q == REQ) && upd_ready_i;

  // Next-state logic: latch a request on a strobe, commit on handshake, then pace by sample strobes.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    band_d  = band_q;
    ugain_d = ugain_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (sample_en_i && win_found) begin
          band_d  = win_band;
          ugain_d = win_step;
          state_d = REQ;
        end
      end
      REQ: begin
        if (handshake) begin
          gain_d[band_q] = ugain_q;
          rr_d           = next_band(band_q);
          if (HOLD_SAMPLES == 0) begin
            state_d = IDLE;
          end else begin
            hold_d  = HOLD_LOAD;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (sample_en_i) begin
          if (hold_q <= HOLD_ONE) begin
            hold_d  = '0;
            state_d = IDLE;
          end else begin
            hold_d = hold_q - HOLD_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any outstanding request without committing it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gain_q  <= '0;
      band_q  <= 2'd0;
      ugain_q <= '0;
      rr_q    <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      band_q  <= band_d;
      ugain_q <= ugain_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

  assign upd_valid_o = (state_q == REQ);
  assign upd_band_o  = band_q;
  assign upd_gain_o  = ugain_q;
  assign gain_o      = gain_q;
  assign busy_o      = (state_q != IDLE) || (|pending);

endmodule

// File: tb/tb_eq_gain_ramp_scheduler.sv
module tb_eq_gain_ramp_scheduler;
  localparam int GW   = 3;
  localparam int GMAX = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sample_en, ready;
  logic [2:0][GW-1:0] target;

  logic vld_h, vld_z, busy_h, busy_z;
  logic [1:0] band_h, band_z;
  logic [GW-1:0] ug_h, ug_z;
  logic [2:0][GW-1:0] gain_h, gain_z;

  eq_gain_ramp_scheduler #(.GAIN_WD(GW), .GAIN_MAX(GMAX), .HOLD_SAMPLES(2), .HOLD_WD(4)) dut_h (
    .clk_i(clk), .rst_i(rst), .sample_en_i(sample_en), .target_gain_i(target),
    .upd_ready_i(ready), .upd_valid_o(vld_h), .upd_band_o(band_h), .upd_gain_o(ug_h),
    .gain_o(gain_h), .busy_o(busy_h));

  eq_gain_ramp_scheduler #(.GAIN_WD(GW), .GAIN_MAX(GMAX), .HOLD_SAMPLES(0), .HOLD_WD(4)) dut_z (
    .clk_i(clk), .rst_i(rst), .sample_en_i(sample_en), .target_gain_i(target),
    .upd_ready_i(ready), .upd_valid_o(vld_z), .upd_band_o(band_z), .upd_gain_o(ug_z),
    .gain_o(gain_z), .busy_o(busy_z));

  int n_pass = 0;
  int n_total = 0;
  int cyc_no = 0;
  int strobes = 0;
  int se_period = 4;

  // Reference model state: index 0 tracks dut_h (hold 2), index 1 tracks dut_z (hold 0).
  int hold_of[2] = '{2, 0};
  int m_g[2][3];
  int m_rr[2];
  bit m_act[2];
  int m_band[2];
  int m_gain[2];
  int m_left[2];

  int hs_band_h[$];
  int hs_gain_h[$];
  int hs_str_h[$];

  typedef struct {
    int se; int t0; int t1; int t2;
    int vld; int band; int gain;
    int g0; int g1; int g2; int busy;
  } row_t;
  row_t rows[15];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int tgt_of(input int b);
    return (int'(target[b]) > GMAX) ? GMAX : int'(target[b]);
  endfunction

  function automatic bit get_vld(input int k);
    return (k == 0) ? vld_h : vld_z;
  endfunction
  function automatic bit get_busy(input int k);
    return (k == 0) ? busy_h : busy_z;
  endfunction
  function automatic int get_g(input int k, input int b);
    return (k == 0) ? int'(gain_h[b]) : int'(gain_z[b]);
  endfunction
  function automatic int get_band(input int k);
    return (k == 0) ? int'(band_h) : int'(band_z);
  endfunction
  function automatic int get_ug(input int k);
    return (k == 0) ? int'(ug_h) : int'(ug_z);
  endfunction

  function automatic int pack(input bit v, input bit b, input int g0, input int g1, input int g2,
                              input int band, input int gain);
    return int'(v) | (int'(b) << 1) | (g0 << 2) | (g1 << 5) | (g2 << 8) | (band << 11) | (gain << 13);
  endfunction

  function automatic bit m_busy(input int k);
    bit any;
    any = m_act[k] || (m_left[k] > 0);
    for (int b = 0; b < 3; b++) if (m_g[k][b] != tgt_of(b)) any = 1'b1;
    return any;
  endfunction

  // One clock of the scheduler rules, applied to the inputs present at the edge.
  task automatic m_step(input int k);
    int w;
    int c;
    if (rst) begin
      for (int b = 0; b < 3; b++) m_g[k][b] = 0;
      m_rr[k] = 0; m_act[k] = 0; m_band[k] = 0; m_gain[k] = 0; m_left[k] = 0;
    end else if (m_act[k]) begin
      if (ready) begin
        m_g[k][m_band[k]] = m_gain[k];
        m_rr[k] = (m_band[k] + 1) % 3;
        m_act[k] = 0;
        m_left[k] = hold_of[k];
      end
    end else if (m_left[k] > 0) begin
      if (sample_en) m_left[k] = m_left[k] - 1;
    end else if (sample_en) begin
      w = -1;
      for (int i = 2; i >= 0; i--) begin
        c = (m_rr[k] + i) % 3;
        if (m_g[k][c] != tgt_of(c)) w = c;
      end
      if (w >= 0) begin
        m_act[k] = 1;
        m_band[k] = w;
        m_gain[k] = (tgt_of(w) > m_g[k][w]) ? m_g[k][w] + 1 : m_g[k][w] - 1;
      end
    end
  endtask

  task automatic cyc(input bit se);
    int exp_v;
    int act_v;
    sample_en = se;
    @(negedge clk);
    if (!rst && vld_h && ready) begin
      hs_band_h.push_back(int'(band_h));
      hs_gain_h.push_back(int'(ug_h));
      hs_str_h.push_back(strobes);
    end
    @(posedge clk);
    m_step(0);
    m_step(1);
    if (se && !rst) strobes++;
    cyc_no++;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_v = pack(m_act[k], m_busy(k), m_g[k][0], m_g[k][1], m_g[k][2],
                   m_act[k] ? m_band[k] : 0, m_act[k] ? m_gain[k] : 0);
      act_v = pack(get_vld(k), get_busy(k), get_g(k, 0), get_g(k, 1), get_g(k, 2),
                   m_act[k] ? get_band(k) : 0, m_act[k] ? get_ug(k) : 0);
      check((k == 0) ? "model_h" : "model_z", act_v, exp_v);
    end
  endtask

  task automatic tick();
    cyc((cyc_no % se_period) == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b0;
    hs_band_h.delete();
    hs_gain_h.delete();
    hs_str_h.delete();
  endtask

  task automatic wait_gain(input int k, input int b, input int val, input int budget, input string name);
    for (int i = 0; i < budget && get_g(k, b) != val; i++) tick();
    check(name, get_g(k, b), val);
  endtask

  task automatic wait_vld(input int k, input int budget, input string name);
    for (int i = 0; i < budget && !get_vld(k); i++) tick();
    check(name, int'(get_vld(k)), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    rows[0]  = '{1, 2, 2, 2, 1, 0, 1, 0, 0, 0, 1};
    rows[1]  = '{1, 2, 2, 2, 0, 0, 0, 1, 0, 0, 1};
    rows[2]  = '{1, 2, 2, 2, 1, 1, 1, 1, 0, 0, 1};
    rows[3]  = '{1, 2, 2, 2, 0, 0, 0, 1, 1, 0, 1};
    rows[4]  = '{1, 2, 2, 2, 1, 2, 1, 1, 1, 0, 1};
    rows[5]  = '{1, 2, 2, 2, 0, 0, 0, 1, 1, 1, 1};
    rows[6]  = '{1, 2, 2, 2, 1, 0, 2, 1, 1, 1, 1};
    rows[7]  = '{1, 2, 2, 2, 0, 0, 0, 2, 1, 1, 1};
    rows[8]  = '{1, 2, 2, 2, 1, 1, 2, 2, 1, 1, 1};
    rows[9]  = '{1, 2, 2, 2, 0, 0, 0, 2, 2, 1, 1};
    rows[10] = '{1, 2, 2, 2, 1, 2, 2, 2, 2, 1, 1};
    rows[11] = '{1, 2, 2, 2, 0, 0, 0, 2, 2, 2, 0};
    rows[12] = '{1, 2, 2, 2, 0, 0, 0, 2, 2, 2, 0};
    rows[13] = '{1, 2, 2, 1, 1, 2, 1, 2, 2, 2, 1};
    rows[14] = '{0, 2, 2, 1, 0, 0, 0, 2, 2, 1, 0};

    // Reset values with zero targets, then quiet after release.
    rst = 1'b1; sample_en = 1'b0; ready = 1'b0; target = '0;
    #1;
    check("rst_gains", int'(gain_h), 0);
    check("rst_vld", int'(vld_h), 0);
    check("rst_busy", int'(busy_h), 0);
    check("rst_band_gain", {int'(band_h), int'(ug_h)} != 0 ? 1 : 0, 0);
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b0;
    se_period = 2;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vld_h || vld_z) cnt++;
    end
    check("idle_no_req", cnt, 0);

    // Round-robin table on the zero-hold instance.
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      target[0] = GW'(rows[i].t0);
      target[1] = GW'(rows[i].t1);
      target[2] = GW'(rows[i].t2);
      cyc(rows[i].se != 0);
      check($sformatf("rr_row%0d_vld", i), int'(vld_z), rows[i].vld);
      check($sformatf("rr_row%0d_busy", i), int'(busy_z), rows[i].busy);
      check($sformatf("rr_row%0d_gains", i), int'(gain_z),
            rows[i].g0 | (rows[i].g1 << GW) | (rows[i].g2 << (2 * GW)));
      if (rows[i].vld != 0)
        check($sformatf("rr_row%0d_req", i), {int'(band_z), int'(ug_z)}, {rows[i].band, rows[i].gain});
    end

    // Single-band ramp with two-sample hold.
    target = '0;
    do_reset();
    ready = 1'b1;
    se_period = 4;
    target[0] = 3'd3;
    for (int i = 0; i < 60; i++) tick();
    check("ramp_hs_count", hs_gain_h.size(), 3);
    if (hs_gain_h.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("ramp_band%0d", i), hs_band_h[i], 0);
        check($sformatf("ramp_gain%0d", i), hs_gain_h[i], i + 1);
      end
      check("ramp_space01", hs_str_h[1] - hs_str_h[0], 3);
      check("ramp_space12", hs_str_h[2] - hs_str_h[1], 3);
    end
    check("ramp_busy_end", int'(busy_h), 0);
    check("ramp_gain_end", int'(gain_h[0]), 3);

    // Backpressure: request 1->2 stalled for 20 cycles.
    target = '0;
    do_reset();
    ready = 1'b1;
    target[0] = 3'd1;
    wait_gain(0, 0, 1, 100, "bp_setup");
    ready = 1'b0;
    target[0] = 3'd4;
    wait_vld(0, 100, "bp_req");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(vld_h && band_h == 2'd0 && ug_h == 3'd2 && gain_h[0] == 3'd1)) cnt++;
    end
    check("bp_stall_bad_cycles", cnt, 0);
    ready = 1'b1;
    cyc(1'b0);
    check("bp_commit_gain", int'(gain_h[0]), 2);
    check("bp_vld_drop", int'(vld_h), 0);

    // Reversal while 4->5 is waiting, then clamp at GAIN_MAX.
    target = '0;
    do_reset();
    ready = 1'b1;
    target[0] = 3'd7;
    wait_gain(0, 0, 4, 200, "rev_reach4");
    ready = 1'b0;
    wait_vld(0, 100, "rev_req");
    check("rev_pending_gain", int'(ug_h), 5);
    target[0] = 3'd3;
    for (int i = 0; i < 5; i++) tick();
    check("rev_held", {int'(vld_h), int'(ug_h)}, {1, 5});
    hs_gain_h.delete();
    ready = 1'b1;
    wait_gain(0, 0, 3, 200, "rev_reach3");
    check("rev_hs_count", hs_gain_h.size(), 3);
    if (hs_gain_h.size() == 3) begin
      check("rev_seq0", hs_gain_h[0], 5);
      check("rev_seq1", hs_gain_h[1], 4);
      check("rev_seq2", hs_gain_h[2], 3);
    end
    target[0] = 3'd7;
    wait_gain(0, 0, 5, 300, "clamp_reach5");
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (vld_h) cnt++;
    end
    check("clamp_no_req", cnt, 0);
    check("clamp_gain", int'(gain_h[0]), 5);
    check("clamp_busy", int'(busy_h), 0);

    // Reset during HOLD and during REQ; restart from IDLE with pointer 0.
    target = '0;
    do_reset();
    ready = 1'b1;
    target[0] = 3'd2;
    wait_gain(0, 0, 1, 100, "mid_setup");
    rst = 1'b1;
    #1;
    check("mid_hold_rst_vld", int'(vld_h), 0);
    check("mid_hold_rst_gains", int'(gain_h), 0);
    cyc(1'b0);
    rst = 1'b0;
    target[0] = 3'd1; target[1] = 3'd1; target[2] = 3'd1;
    ready = 1'b0;
    wait_vld(0, 100, "mid_req1");
    check("mid_first_band", int'(band_h), 0);
    ready = 1'b1;
    cyc(1'b0);
    ready = 1'b0;
    wait_vld(0, 100, "mid_req2");
    check("mid_second_band", int'(band_h), 1);
    rst = 1'b1;
    #1;
    check("mid_req_rst_vld", int'(vld_h), 0);
    check("mid_req_rst_gains", int'(gain_h), 0);
    cyc(1'b0);
    rst = 1'b0;
    wait_vld(0, 100, "mid_req3");
    check("mid_restart_band", int'(band_h), 0);

    // Randomized traffic against the reference model.
    ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) target[$urandom_range(0, 2)] = GW'($urandom_range(0, 7));
      ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 2) == 0);
    end
    rst = 1'b0;
    cyc(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
